// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Generates SVGA raster timing (default 800x600 visible, 1056x628 total)
//   and the visible pixel coordinates for the downstream draw stages. Every
//   output is registered from the next-state counters. Outputs therefore
//   always describe the same raster position as the internal counters, and
//   draw stages can be purely combinational on row/col.
//
//   Ports:
//     clock       - system clock
//     reset       - synchronous, active-high; takes priority over pix_en
//     pix_en      - pixel tick; the raster advances one pixel per enabled clock
//     row, col    - visible line / pixel index, forced to 0 while blanked
//     hsync/vsync - sync pulses, active level selected by SYNC_POL
//     blank       - 1 outside the visible region
//     line_end    - single-clock pulse while at the last pixel of a line
//     frame_end   - single-clock pulse while at the last pixel of a frame
//     frame_count - (only with VGA_FRAME_COUNT_EN) 16-bit wrapping frame counter
//
//   Optional feature macro: VGA_FRAME_COUNT_EN adds the frame_count output.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_VISIBLE = 800,
  parameter int H_FRONT   = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BACK    = 88,
  parameter int V_VISIBLE = 600,
  parameter int V_FRONT   = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BACK    = 23,
  parameter bit SYNC_POL  = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pix_en,
  output logic [9:0]  row,
  output logic [9:0]  col,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        line_end,
`ifdef VGA_FRAME_COUNT_EN
  output logic        frame_end,
  output logic [15:0] frame_count
`else
  output logic        frame_end
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Refuse to elaborate with timing that the 11-bit counters or the 10-bit
  // coordinate outputs cannot represent, or with a zero-length phase that
  // would make two state boundaries coincide.
  if (H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
      H_VISIBLE < 1 || V_VISIBLE < 1 ||
      H_VISIBLE > 1023 || V_VISIBLE > 1023 ||
      H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_params
    $fatal(1, "vga_timing_gen: illegal timing parameters");
  end

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_FP_START = 11'(H_VISIBLE);
  localparam logic [10:0] H_SY_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_BP_START = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_FP_START = 11'(V_VISIBLE);
  localparam logic [10:0] V_SY_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] V_BP_START = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic        SYNC_ON    = SYNC_POL;

  // The horizontal and vertical FSMs share one state encoding.
  typedef enum logic [1:0] {
    ST_VIS  = 2'd0,
    ST_FP   = 2'd1,
    ST_SYNC = 2'd2,
    ST_BP   = 2'd3
  } phase_e;

  logic [10:0] h_count_q, h_count_d;
  logic [10:0] v_count_q, v_count_d;
  phase_e      h_state_q, h_state_d;
  phase_e      v_state_q, v_state_d;
  logic [9:0]  row_q, row_d;
  logic [9:0]  col_q, col_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        blank_q, blank_d;
  logic        line_end_q, line_end_d;
  logic        frame_end_q, frame_end_d;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count_q, frame_count_d;
`endif

  // A phase changes only when its counter lands exactly on a boundary.
  // Counters step by one, so every boundary is always hit.
  function automatic phase_e next_phase(input phase_e cur, input logic [10:0] cnt,
                                        input logic [10:0] fp, input logic [10:0] sy,
                                        input logic [10:0] bp);
    phase_e nxt;
    nxt = cur;
    if (cnt == 11'd0)  nxt = ST_VIS;
    else if (cnt == fp) nxt = ST_FP;
    else if (cnt == sy) nxt = ST_SYNC;
    else if (cnt == bp) nxt = ST_BP;
    return nxt;
  endfunction

  // Next raster position and FSM phases. With pix_en low everything holds.
  // The vertical side moves only on the tick that wraps the line.
  always_comb begin
    h_count_d = h_count_q;
    v_count_d = v_count_q;
    h_state_d = h_state_q;
    v_state_d = v_state_q;
    if (pix_en) begin
      if (h_count_q == H_LAST) begin
        h_count_d = 11'd0;
        v_count_d = (v_count_q == V_LAST) ? 11'd0 : v_count_q + 11'd1;
        v_state_d = next_phase(v_state_q, v_count_d, V_FP_START, V_SY_START, V_BP_START);
      end else begin
        h_count_d = h_count_q + 11'd1;
      end
      h_state_d = next_phase(h_state_q, h_count_d, H_FP_START, H_SY_START, H_BP_START);
    end
  end

  // Output values are derived from the next position, so each registered
  // output lines up with the counters of that same clock. The end pulses
  // require pix_en, so they drop after one clock even if pix_en stays low.
  always_comb begin
    blank_d     = (h_state_d != ST_VIS) || (v_state_d != ST_VIS);
    row_d       = blank_d ? 10'd0 : v_count_d[9:0];
    col_d       = blank_d ? 10'd0 : h_count_d[9:0];
    hsync_d     = (h_state_d == ST_SYNC) ? SYNC_ON : ~SYNC_ON;
    vsync_d     = (v_state_d == ST_SYNC) ? SYNC_ON : ~SYNC_ON;
    line_end_d  = pix_en && (h_count_d == H_LAST);
    frame_end_d = line_end_d && (v_count_d == V_LAST);
`ifdef VGA_FRAME_COUNT_EN
    frame_count_d = frame_end_d ? frame_count_q + 16'd1 : frame_count_q;
`endif
  end

  // Single state register for both FSMs, the counters and all outputs.
  // Reset restarts the raster at the visible pixel (0,0) immediately,
  // without finishing the current line.
  always_ff @(posedge clock) begin
    if (reset) begin
      h_count_q   <= 11'd0;
      v_count_q   <= 11'd0;
      h_state_q   <= ST_VIS;
      v_state_q   <= ST_VIS;
      row_q       <= 10'd0;
      col_q       <= 10'd0;
      hsync_q     <= ~SYNC_ON;
      vsync_q     <= ~SYNC_ON;
      blank_q     <= 1'b0;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
`ifdef VGA_FRAME_COUNT_EN
      frame_count_q <= 16'd0;
`endif
    end else begin
      h_count_q   <= h_count_d;
      v_count_q   <= v_count_d;
      h_state_q   <= h_state_d;
      v_state_q   <= v_state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      blank_q     <= blank_d;
      line_end_q  <= line_end_d;
      frame_end_q <= frame_end_d;
`ifdef VGA_FRAME_COUNT_EN
      frame_count_q <= frame_count_d;
`endif
    end
  end

  assign row       = row_q;
  assign col       = col_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign blank     = blank_q;
  assign line_end  = line_end_q;
  assign frame_end = frame_end_q;
`ifdef VGA_FRAME_COUNT_EN
  assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Drives two instances from shared reset/pix_en: "a" with default SVGA
//   timing and "b" with a tiny raster (17x10, active-low sync) so that whole
//   frames and frame_count wrap-arounds fit in a short run. Each drive step
//   pushes a reference-model expectation per instance, and the step's
//   outputs are popped and compared at the following negedge.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int B_HV = 10, B_HF = 2, B_HS = 3, B_HB = 2;
  localparam int B_VV = 6,  B_VF = 1, B_VS = 2, B_VB = 1;

  typedef struct {
    int row;
    int col;
    bit hs;
    bit vs;
    bit bl;
    bit le;
    bit fe;
    int fc;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  logic pix_en;

  logic [9:0] row_a, col_a, row_b, col_b;
  logic hsync_a, vsync_a, blank_a, line_end_a, frame_end_a;
  logic hsync_b, vsync_b, blank_b, line_end_b, frame_end_b;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] fc_a, fc_b;
`endif

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  exp_t qa[$];
  exp_t qb[$];

  int ha = 0, va = 0, fca = 0;
  int hb = 0, vb = 0, fcb = 0;
  bit lea, fea, leb, feb;

  always #5 clock = ~clock;

  vga_timing_gen u_dut_a (
    .clock(clock), .reset(reset), .pix_en(pix_en),
    .row(row_a), .col(col_a), .hsync(hsync_a), .vsync(vsync_a), .blank(blank_a),
    .line_end(line_end_a),
`ifdef VGA_FRAME_COUNT_EN
    .frame_end(frame_end_a), .frame_count(fc_a)
`else
    .frame_end(frame_end_a)
`endif
  );

  vga_timing_gen #(
    .H_VISIBLE(B_HV), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
    .V_VISIBLE(B_VV), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB),
    .SYNC_POL(1'b0)
  ) u_dut_b (
    .clock(clock), .reset(reset), .pix_en(pix_en),
    .row(row_b), .col(col_b), .hsync(hsync_b), .vsync(vsync_b), .blank(blank_b),
    .line_end(line_end_b),
`ifdef VGA_FRAME_COUNT_EN
    .frame_end(frame_end_b), .frame_count(fc_b)
`else
    .frame_end(frame_end_b)
`endif
  );

  // Single comparison point: every check in the bench goes through here.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s step=%0d observed=%0d expected=%0d", tag, step_no, obs, exp);
    end
  endtask

  // Reference raster model: advance position one step.
  task automatic model_step(input bit rst_i, input bit pe_i, input int ht, input int vt,
                            inout int h, inout int v, inout int fc,
                            output bit le, output bit fe);
    le = 1'b0;
    fe = 1'b0;
    if (rst_i) begin
      h = 0; v = 0; fc = 0;
    end else if (pe_i) begin
      if (h == ht - 1) begin
        h = 0;
        v = (v == vt - 1) ? 0 : v + 1;
      end else begin
        h = h + 1;
      end
      le = (h == ht - 1);
      fe = le && (v == vt - 1);
      if (fe) fc = (fc + 1) % 65536;
    end
  endtask

  // Expected outputs for a raster position, straight from the timing numbers.
  function automatic exp_t expect_of(input int h, input int v, input int fc,
                                     input bit le, input bit fe,
                                     input int hv, input int hf, input int hs,
                                     input int vv, input int vf, input int vs,
                                     input bit pol);
    exp_t e;
    bit h_act, v_act;
    e.bl  = (h >= hv) || (v >= vv);
    e.row = e.bl ? 0 : v;
    e.col = e.bl ? 0 : h;
    h_act = (h >= hv + hf) && (h < hv + hf + hs);
    v_act = (v >= vv + vf) && (v < vv + vf + vs);
    e.hs  = pol ? h_act : !h_act;
    e.vs  = pol ? v_act : !v_act;
    e.le  = le;
    e.fe  = fe;
    e.fc  = fc;
    return e;
  endfunction

  task automatic compare_one(input string who, input exp_t e,
                             input logic [9:0] r, input logic [9:0] c,
                             input logic hs, input logic vs, input logic bl,
                             input logic le, input logic fe, input logic [15:0] fc);
    chk({who, ".row"}, 32'(r), 32'(e.row));
    chk({who, ".col"}, 32'(c), 32'(e.col));
    chk({who, ".hsync"}, 32'(hs), 32'(e.hs));
    chk({who, ".vsync"}, 32'(vs), 32'(e.vs));
    chk({who, ".blank"}, 32'(bl), 32'(e.bl));
    chk({who, ".line_end"}, 32'(le), 32'(e.le));
    chk({who, ".frame_end"}, 32'(fe), 32'(e.fe));
`ifdef VGA_FRAME_COUNT_EN
    chk({who, ".frame_count"}, 32'(fc), 32'(e.fc));
`else
    if (fc !== 16'd0) chk({who, ".frame_count_stub"}, 32'(fc), 32'd0);
`endif
  endtask

  // Pop the scoreboard entries for the step just clocked and compare.
  task automatic checkOutput();
    exp_t e;
    logic [15:0] fa, fb;
`ifdef VGA_FRAME_COUNT_EN
    fa = fc_a;
    fb = fc_b;
`else
    fa = 16'd0;
    fb = 16'd0;
`endif
    if (qa.size() == 0 || qb.size() == 0) begin
      chk("scoreboard_empty", 32'(qa.size() + qb.size()), 32'd2);
    end else begin
      e = qa.pop_front();
      compare_one("a", e, row_a, col_a, hsync_a, vsync_a, blank_a, line_end_a, frame_end_a, fa);
      e = qb.pop_front();
      compare_one("b", e, row_b, col_b, hsync_b, vsync_b, blank_b, line_end_b, frame_end_b, fb);
    end
  endtask

  // Drive one clock's inputs (at a negedge), record expectations, then
  // check the result at the next negedge, away from the active edge.
  task automatic applyStimulus(input bit rst_i, input bit pe_i);
    reset  = rst_i;
    pix_en = pe_i;
    step_no++;
    model_step(rst_i, pe_i, 1056, 628, ha, va, fca, lea, fea);
    qa.push_back(expect_of(ha, va, fca, lea, fea, 800, 40, 128, 600, 1, 4, 1'b1));
    model_step(rst_i, pe_i, B_HV + B_HF + B_HS + B_HB, B_VV + B_VF + B_VS + B_VB,
               hb, vb, fcb, leb, feb);
    qb.push_back(expect_of(hb, vb, fcb, leb, feb, B_HV, B_HF, B_HS, B_VV, B_VF, B_VS, 1'b0));
    @(negedge clock);
    checkOutput();
  endtask

  initial begin
    reset  = 1'b1;
    pix_en = 1'b1;
    @(negedge clock);

    // Reset held three cycles with pix_en high.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
    chk("rst_row_a", 32'(row_a), 32'd0);
    chk("rst_col_a", 32'(col_a), 32'd0);
    chk("rst_blank_a", 32'(blank_a), 32'd0);
    chk("rst_hsync_a", 32'(hsync_a), 32'd0);
    chk("rst_vsync_a", 32'(vsync_a), 32'd0);
    chk("rst_hsync_b_low_pol", 32'(hsync_b), 32'd1);

    // First line of instance a; b cycles through several small frames.
    for (int i = 1; i <= 1055; i++) begin
      applyStimulus(1'b0, 1'b1);
      if (i == 799)  chk("col_799", 32'(col_a), 32'd799);
      if (i == 800)  begin
        chk("blank_at_800", 32'(blank_a), 32'd1);
        chk("col_0_at_800", 32'(col_a), 32'd0);
      end
      if (i == 839)  chk("hsync_low_839", 32'(hsync_a), 32'd0);
      if (i == 840)  chk("hsync_high_840", 32'(hsync_a), 32'd1);
      if (i == 967)  chk("hsync_high_967", 32'(hsync_a), 32'd1);
      if (i == 968)  chk("hsync_low_968", 32'(hsync_a), 32'd0);
      if (i == 1054) chk("line_end_low_1054", 32'(line_end_a), 32'd0);
      if (i == 1055) chk("line_end_1055", 32'(line_end_a), 32'd1);
      if (i == 118)  chk("b_vsync_off_line6", 32'(vsync_b), 32'd1);
      if (i == 119)  chk("b_vsync_on_line7", 32'(vsync_b), 32'd0);
      if (i == 152)  chk("b_vsync_on_line8", 32'(vsync_b), 32'd0);
      if (i == 153)  chk("b_vsync_off_line9", 32'(vsync_b), 32'd1);
      if (i == 169)  chk("b_frame_end", 32'(frame_end_b), 32'd1);
      if (i == 170)  begin
        chk("b_frame_end_cleared", 32'(frame_end_b), 32'd0);
        chk("b_row_wrap", 32'(row_b), 32'd0);
        chk("b_col_wrap", 32'(col_b), 32'd0);
        chk("b_blank_wrap", 32'(blank_b), 32'd0);
      end
`ifdef VGA_FRAME_COUNT_EN
      if (i == 510) chk("b_frame_count_3", 32'(fc_b), 32'd3);
`endif
    end

    // pix_en 0-0-1 right after line_end: pulse lasts one clock, outputs hold.
    applyStimulus(1'b0, 1'b0);
    chk("line_end_one_clock", 32'(line_end_a), 32'd0);
    chk("hold_blank", 32'(blank_a), 32'd1);
    applyStimulus(1'b0, 1'b0);
    chk("hold_line_end", 32'(line_end_a), 32'd0);
    applyStimulus(1'b0, 1'b1);
    chk("next_line_row", 32'(row_a), 32'd1);
    chk("next_line_col", 32'(col_a), 32'd0);
    chk("next_line_blank", 32'(blank_a), 32'd0);

    // Move into the middle of the visible area, then reset mid-line.
    for (int i = 0; i < 400; i++) applyStimulus(1'b0, 1'b1);
    chk("mid_col", 32'(col_a), 32'd400);
    applyStimulus(1'b1, 1'b1);
    chk("mid_rst_row", 32'(row_a), 32'd0);
    chk("mid_rst_col", 32'(col_a), 32'd0);
    chk("mid_rst_blank", 32'(blank_a), 32'd0);
    chk("mid_rst_hsync", 32'(hsync_a), 32'd0);
`ifdef VGA_FRAME_COUNT_EN
    chk("b_frame_count_rst", 32'(fc_b), 32'd0);
`endif

    // Timing restarts from (0,0).
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1);
    chk("restart_col", 32'(col_a), 32'd20);
    chk("restart_row", 32'(row_a), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
